// File: rtl/bip_program_loader.sv
// Program-memory writer for BIP1: pairs UART bytes (high first) into instructions,
// stores them from address 0 and releases the CPU reset once the HALT word lands.
module bip_program_loader #(
   parameter int NB_INSTRUC = 16,
   parameter int NB_OPCODE  = 5,
   parameter int NB_ADDR    = 11,
   parameter int MEM_DEPTH  = 2048
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_done,
   output logic                  o_wr_en,
   output logic [NB_ADDR-1:0]    o_wr_addr,
   output logic [NB_INSTRUC-1:0] o_wr_data,
   output logic                  o_cpu_rst_n,
   output logic                  o_loading,
   output logic                  o_done,
   output logic                  o_error
);

   typedef enum logic [2:0] {
      WAIT_HI = 3'd0,
      WAIT_LO = 3'd1,
      WRITE   = 3'd2,
      DONE    = 3'd3,
      ERROR   = 3'd4
   } state_t;

   localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEM_DEPTH - 1);

   state_t                  state;
   logic [NB_ADDR-1:0]      counter;
   logic [NB_INSTRUC-9:0]   hi;
   logic                    is_halt;

   assign is_halt = (o_wr_data[NB_INSTRUC-1 -: NB_OPCODE] == '0);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state       <= WAIT_HI;
         counter     <= '0;
         hi          <= '0;
         o_wr_en     <= 1'b0;
         o_wr_addr   <= '0;
         o_wr_data   <= '0;
         o_cpu_rst_n <= 1'b0;
         o_loading   <= 1'b1;
         o_done      <= 1'b0;
         o_error     <= 1'b0;
      end else begin
         case (state)
            WAIT_HI: begin
               o_wr_en <= 1'b0;
               if (i_rx_done) begin
                  hi    <= i_rx_data;
                  state <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               if (i_rx_done) begin
                  o_wr_data <= {hi, i_rx_data};
                  o_wr_addr <= counter;
                  o_wr_en   <= 1'b1;
                  state     <= WRITE;
               end
            end
            WRITE: begin
               // HALT wins over the full-memory check, so a HALT in the last slot still boots.
               o_wr_en <= 1'b0;
               if (is_halt) begin
                  state       <= DONE;
                  o_loading   <= 1'b0;
                  o_done      <= 1'b1;
                  o_cpu_rst_n <= 1'b1;
               end else if (counter == LAST_ADDR) begin
                  state     <= ERROR;
                  o_loading <= 1'b0;
                  o_error   <= 1'b1;
               end else begin
                  counter <= counter + 1'b1;
                  state   <= WAIT_HI;
               end
            end
            DONE, ERROR: o_wr_en <= 1'b0;
            default: state <= WAIT_HI;
         endcase
      end
   end

endmodule

// File: tb/tb_bip_program_loader.sv
// Scoreboard bench: a default-depth loader and a 4-word loader, expected writes queued
// as bytes are driven and matched against every observed write strobe.
module tb_bip_program_loader;

   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   logic [7:0]  rxd_a, rxd_b;
   logic        rxv_a, rxv_b;
   logic        we_a, we_b;
   logic [10:0] wa_a, wa_b;
   logic [15:0] wd_a, wd_b;
   logic        crn_a, crn_b, ld_a, ld_b, dn_a, dn_b, er_a, er_b;

   int checks = 0;
   int errors = 0;
   logic [26:0] q_a[$];
   logic [26:0] q_b[$];
   logic        halt_a = 1'b0, halt_b = 1'b0;

   always #5 clk = ~clk;

   bip_program_loader dut_a (
      .i_clk(clk), .i_rst(rst_a), .i_rx_data(rxd_a), .i_rx_done(rxv_a),
      .o_wr_en(we_a), .o_wr_addr(wa_a), .o_wr_data(wd_a), .o_cpu_rst_n(crn_a),
      .o_loading(ld_a), .o_done(dn_a), .o_error(er_a));

   bip_program_loader #(.MEM_DEPTH(4)) dut_b (
      .i_clk(clk), .i_rst(rst_b), .i_rx_data(rxd_b), .i_rx_done(rxv_b),
      .o_wr_en(we_b), .o_wr_addr(wa_b), .o_wr_data(wd_b), .o_cpu_rst_n(crn_b),
      .o_loading(ld_b), .o_done(dn_b), .o_error(er_b));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Write monitors: every strobe must match the head of the queue; HALT raises cpu reset next cycle.
   always @(negedge clk) begin
      if (halt_a) chk("a_cpu_rst_lat", {31'd0, crn_a}, 32'd1);
      halt_a <= 1'b0;
      if (we_a) begin
         chk("a_cpu_rst_in_wr", {31'd0, crn_a}, 32'd0);
         if (q_a.size() == 0) chk("a_unexpected_wr", {5'd0, wa_a, wd_a}, 32'hFFFF_FFFF);
         else chk("a_wr", {5'd0, wa_a, wd_a}, {5'd0, q_a.pop_front()});
         if (wd_a[15:11] == 5'd0) halt_a <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (halt_b) chk("b_cpu_rst_lat", {31'd0, crn_b}, 32'd1);
      halt_b <= 1'b0;
      if (we_b) begin
         chk("b_cpu_rst_in_wr", {31'd0, crn_b}, 32'd0);
         if (q_b.size() == 0) chk("b_unexpected_wr", {5'd0, wa_b, wd_b}, 32'hFFFF_FFFF);
         else chk("b_wr", {5'd0, wa_b, wd_b}, {5'd0, q_b.pop_front()});
         if (wd_b[15:11] == 5'd0) halt_b <= 1'b1;
      end
   end

   task automatic send(input bit b, input logic [7:0] d);
      @(negedge clk);
      if (b) begin rxd_b = d; rxv_b = 1'b1; end
      else   begin rxd_a = d; rxv_a = 1'b1; end
      @(negedge clk);
      rxv_a = 1'b0; rxv_b = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic word(input bit b, input logic [10:0] addr, input logic [15:0] w, input bit expect_wr);
      if (expect_wr) begin
         if (b) q_b.push_back({addr, w});
         else   q_a.push_back({addr, w});
      end
      send(b, w[15:8]);
      send(b, w[7:0]);
   endtask

   task automatic do_reset(input bit b);
      @(negedge clk);
      if (b) rst_b = 1'b0; else rst_a = 1'b0;
      @(negedge clk);
      if (b) rst_b = 1'b1; else rst_a = 1'b1;
   endtask

   // status = {cpu_rst_n, loading, done, error}
   function automatic logic [31:0] st_a();
      return {28'd0, crn_a, ld_a, dn_a, er_a};
   endfunction
   function automatic logic [31:0] st_b();
      return {28'd0, crn_b, ld_b, dn_b, er_b};
   endfunction

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      rxd_a = 8'h00; rxd_b = 8'h00; rxv_a = 1'b0; rxv_b = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_status", st_a(), 32'b0100);
      chk("rst_wr", {4'd0, we_a, wa_a, wd_a}, 32'd0);
      rst_a = 1'b1; rst_b = 1'b1;

      // Three-word program ending in HALT
      word(0, 11'd0, 16'h0805, 1);
      word(0, 11'd1, 16'h1003, 1);
      word(0, 11'd2, 16'h0000, 1);
      repeat (3) @(negedge clk);
      chk("t1_status", st_a(), 32'b1010);
      chk("t1_q_empty", q_a.size(), 0);

      // DONE ignores further bytes and holds its outputs
      word(0, 11'd0, 16'h0805, 0);
      repeat (3) @(negedge clk);
      chk("t5_status", st_a(), 32'b1010);
      chk("t5_hold", {5'd0, wa_a, wd_a}, {5'd0, 11'd2, 16'h0000});

      // Reset after a word, then reload from address 0
      do_reset(0);
      chk("t2_rst_status", st_a(), 32'b0100);
      word(0, 11'd0, 16'h0805, 1);
      do_reset(0);
      word(0, 11'd0, 16'h0000, 1);
      repeat (3) @(negedge clk);
      chk("t2_status", st_a(), 32'b1010);

      // Reset in the middle of a word discards the high byte
      do_reset(0);
      send(0, 8'h08);
      do_reset(0);
      word(0, 11'd0, 16'h2000, 1);
      word(0, 11'd1, 16'h0000, 1);
      repeat (3) @(negedge clk);
      chk("t2b_status", st_a(), 32'b1010);

      // Lone high byte waits indefinitely, then completes when the low byte comes
      do_reset(0);
      send(0, 8'h08);
      repeat (1000) @(negedge clk);
      chk("t6_status", st_a(), 32'b0100);
      chk("t6_no_wr", q_a.size(), 0);
      q_a.push_back({11'd0, 16'h0805});
      send(0, 8'h05);
      repeat (2) @(negedge clk);
      chk("t6_q_empty", q_a.size(), 0);

      // Small memory filled without HALT -> ERROR
      do_reset(1);
      for (int i = 0; i < 4; i++) word(1, 11'(i), 16'h0801, 1);
      repeat (3) @(negedge clk);
      chk("t3_status", st_b(), 32'b0001);
      word(1, 11'd0, 16'h0000, 0);
      repeat (3) @(negedge clk);
      chk("t3_stuck", st_b(), 32'b0001);
      chk("t3_q_empty", q_b.size(), 0);

      // HALT in the last slot -> DONE
      do_reset(1);
      chk("t4_rst_status", st_b(), 32'b0100);
      for (int i = 0; i < 3; i++) word(1, 11'(i), 16'h0801, 1);
      word(1, 11'd3, 16'h0000, 1);
      repeat (3) @(negedge clk);
      chk("t4_status", st_b(), 32'b1010);
      chk("t4_q_empty", q_b.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
